multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Control FSM driving the control inputs of the core datapath: memToReg, pcSrc, aluSrc, regDst, writeEnable, jump and aluControl.
- Adds the strobes a multi-cycle core needs: pcWrite, irWrite, memRead and memWrite.
- Handshakes with the unified instruction/data memory through memReady, stretching any memory state until memory responds.
- Sits between the instruction register (opcode/funct in) and the datapath/memory (controls out).

Parameters:
- OPW, 6, opcode field width.
- FW, 6, funct field width.
- TIMEOUT, 15, maximum cycles spent waiting for memReady before the bus error is flagged.
- CW, 4, width of the wait counter; must satisfy 2^CW > TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- opcode  input  OPW  opcode field of the instruction register.
- funct  input  FW  function field; meaningful for R-type only.
- zero  input  1  ALU zero flag from the datapath.
- memReady  input  1  memory has completed the current read or write this cycle.
- memToReg, pcSrc, aluSrc, regDst, writeEnable, jump  output  1 each  datapath controls.
- aluControl  output  4  ALU operation select.
- pcWrite, irWrite, memRead, memWrite  output  1 each  PC load, IR load, memory read request, memory write request.
- illegal  output  1  one-cycle pulse when an unknown opcode is decoded.
- busError  output  1  sticky memory-timeout flag.
- halted  output  1  high while in HALT.
- state  output  4  current state, for debug.

Behaviour:
- Opcodes:
  - RTYPE 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010, HALT 111111.
  - All other opcodes are illegal.
- aluControl codes: ADD 0010, SUB 0110, AND 0000, OR 0001, SLT 0111.
- funct decode: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT.
- Unknown funct: aluControl=ADD, ALUWB is skipped, EXECUTE returns to FETCH.
- States (encoding 0-11): FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP. HALT=15.
- Reset (next edge after reset=1):
  - state←FETCH, wait counter←0, busError←0.
  - While reset is high, every output is forced to 0.
- Default: every output not listed for a state is 0.
- Outputs are a Moore decode of state, except pcSrc, which is Mealy on zero.
- FETCH:
  - memRead=1.
  - When memReady=1: irWrite=1, pcWrite=1, next state DECODE.
  - Otherwise stay in FETCH.
- DECODE, next state by opcode:
  - LW or SW → MEMADR.
  - RTYPE → EXECUTE.
  - BEQ → BRANCH.
  - ADDI → ADDIEX.
  - J → JUMP.
  - HALT → HALT.
  - Illegal → FETCH, with illegal=1 for this cycle.
- MEMADR: aluSrc=1, aluControl=ADD. Next state MEMRD for LW, MEMWR for SW.
- MEMRD: memRead=1; aluSrc=1 and aluControl=ADD are held so the address is stable. Leaves to MEMWB on memReady.
- MEMWB: memToReg=1, regDst=0, writeEnable=1 → FETCH.
- MEMWR: memWrite=1, with aluSrc/aluControl held as in MEMADR. Leaves to FETCH on memReady.
- EXECUTE: aluSrc=0, aluControl=funct decode. Next state ALUWB, or FETCH for an unknown funct.
- ALUWB: regDst=1, writeEnable=1, aluControl held → FETCH.
- BRANCH: aluControl=SUB, pcSrc=zero, pcWrite=zero → FETCH.
- ADDIEX: aluSrc=1, aluControl=ADD → ADDIWB.
- ADDIWB: aluSrc=1, aluControl=ADD, regDst=0, writeEnable=1 → FETCH.
- JUMP: jump=1, pcWrite=1 → FETCH.
- HALT: halted=1; all strobes 0; stays in HALT until reset.
- Latency with zero-wait memory:
  - R-type, SW, ADDI: 4 cycles.
  - LW: 5 cycles.
  - BEQ, J: 3 cycles.
  - Each wait cycle in FETCH, MEMRD or MEMWR adds 1.
- Wait counter:
  - Cleared on entry to any memory state and on every cycle memReady=1.
  - Increments on each cycle spent in a memory state with memReady=0.
  - When it reaches TIMEOUT with memReady still 0: busError←1 (sticky), next state HALT, no strobe issued that cycle.
  - memReady=1 in the same cycle the count reaches TIMEOUT: completion wins, no error.
- memReady outside FETCH, MEMRD and MEMWR is ignored.
- Reset asserted mid-instruction aborts it. No writeEnable, memWrite or pcWrite is asserted in the reset cycle.
- Opcode and funct are sampled only in DECODE and EXECUTE. Changes at other times have no effect.

Test Plan:
- Reset → state=0, all outputs 0. First cycle after release: memRead=1, irWrite=0 while memReady=0.
- R-type ADD (funct 100000), memReady always 1 → states 0,1,6,7. In ALUWB: aluControl=0010, regDst=1, writeEnable=1. Total 4 cycles.
- LW with memReady low for 3 cycles in MEMRD → memRead held 3 cycles, then MEMWB with memToReg=1, writeEnable=1. Total 8 cycles.
- BEQ with zero=1, then zero=0 → pcSrc=1/pcWrite=1 in the first BRANCH, pcSrc=0/pcWrite=0 in the second. Both return to FETCH.
- Opcode 010101 → illegal pulses 1 cycle in DECODE, back to FETCH. HALT opcode → halted=1, no strobes for 20 cycles.
- memReady held 0 in FETCH → busError=1 and HALT after 15 wait cycles. Same stimulus with memReady=1 exactly at the 15th cycle → no error, DECODE next.

Source files
------------

// File: rtl/multicycle_control_if.sv
`default_nettype none
// =============================================================================
// multicycle_control_if : controller <-> IR/datapath/memory signal bundle (rev 1.0)
// =============================================================================
interface multicycle_control_if #(
  parameter int OPW = 6,
  parameter int FW  = 6
);
  logic [OPW-1:0] opcode;
  logic [FW-1:0]  funct;
  logic           zero;
  logic           memReady;

  logic           memToReg;
  logic           pcSrc;
  logic           aluSrc;
  logic           regDst;
  logic           writeEnable;
  logic           jump;
  logic [3:0]     aluControl;
  logic           pcWrite;
  logic           irWrite;
  logic           memRead;
  logic           memWrite;
  logic           illegal;
  logic           busError;
  logic           halted;
  logic [3:0]     state;

  modport master (
    input  opcode, funct, zero, memReady,
    output memToReg, pcSrc, aluSrc, regDst, writeEnable, jump, aluControl,
           pcWrite, irWrite, memRead, memWrite, illegal, busError, halted, state
  );

  modport slave (
    output opcode, funct, zero, memReady,
    input  memToReg, pcSrc, aluSrc, regDst, writeEnable, jump, aluControl,
           pcWrite, irWrite, memRead, memWrite, illegal, busError, halted, state
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// =============================================================================
// multicycle_control : multi-cycle core control FSM with memReady wait/timeout (rev 1.0)
// =============================================================================
module multicycle_control #(
  parameter int OPW     = 6,
  parameter int FW      = 6,
  parameter int TIMEOUT = 15,
  parameter int CW      = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_control_if.master   bus
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXECUTE = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;
  localparam logic [3:0] S_HALT    = 4'd15;

  localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
  localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);
  localparam logic [OPW-1:0] OP_HALT  = OPW'(6'b111111);

  localparam logic [FW-1:0] FN_ADD = FW'(6'b100000);
  localparam logic [FW-1:0] FN_SUB = FW'(6'b100010);
  localparam logic [FW-1:0] FN_AND = FW'(6'b100100);
  localparam logic [FW-1:0] FN_OR  = FW'(6'b100101);
  localparam logic [FW-1:0] FN_SLT = FW'(6'b101010);

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [CW:0] WAIT_LIMIT = (CW+1)'(TIMEOUT);

  logic [3:0]    r_state;
  logic [3:0]    w_next;
  logic [CW-1:0] r_wait;
  logic          r_bus_err;
  logic          r_is_sw;
  logic [3:0]    r_alu_hold;
  logic [3:0]    w_funct_alu;
  logic          w_funct_ok;
  logic          w_in_mem;
  logic [CW:0]   w_wait_inc;
  logic          w_timeout;

  assign w_in_mem   = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  assign w_wait_inc = {1'b0, r_wait} + 1'b1;
  // Completion on the limiting cycle wins because the timeout needs memReady low.
  assign w_timeout  = w_in_mem && !bus.memReady && (w_wait_inc == WAIT_LIMIT);

  always_comb begin
    w_funct_alu = ALU_ADD;
    w_funct_ok  = 1'b1;
    case (bus.funct)
      FN_ADD:  w_funct_alu = ALU_ADD;
      FN_SUB:  w_funct_alu = ALU_SUB;
      FN_AND:  w_funct_alu = ALU_AND;
      FN_OR:   w_funct_alu = ALU_OR;
      FN_SLT:  w_funct_alu = ALU_SLT;
      default: w_funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    w_next          = r_state;
    bus.memToReg    = 1'b0;
    bus.pcSrc       = 1'b0;
    bus.aluSrc      = 1'b0;
    bus.regDst      = 1'b0;
    bus.writeEnable = 1'b0;
    bus.jump        = 1'b0;
    bus.aluControl  = 4'b0000;
    bus.pcWrite     = 1'b0;
    bus.irWrite     = 1'b0;
    bus.memRead     = 1'b0;
    bus.memWrite    = 1'b0;
    bus.illegal     = 1'b0;
    bus.busError    = 1'b0;
    bus.halted      = 1'b0;
    bus.state       = 4'd0;

    case (r_state)
      S_FETCH: begin
        bus.memRead = 1'b1;
        if (w_timeout) begin
          w_next = S_HALT;
        end else if (bus.memReady) begin
          bus.irWrite = 1'b1;
          bus.pcWrite = 1'b1;
          w_next      = S_DECODE;
        end
      end
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          OP_HALT:      w_next = S_HALT;
          default: begin
            bus.illegal = 1'b1;
            w_next      = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        bus.aluSrc     = 1'b1;
        bus.aluControl = ALU_ADD;
        w_next         = r_is_sw ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        bus.memRead    = 1'b1;
        bus.aluSrc     = 1'b1;
        bus.aluControl = ALU_ADD;
        if (w_timeout)         w_next = S_HALT;
        else if (bus.memReady) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        bus.memToReg    = 1'b1;
        bus.writeEnable = 1'b1;
        w_next          = S_FETCH;
      end
      S_MEMWR: begin
        bus.memWrite   = 1'b1;
        bus.aluSrc     = 1'b1;
        bus.aluControl = ALU_ADD;
        if (w_timeout)         w_next = S_HALT;
        else if (bus.memReady) w_next = S_FETCH;
      end
      S_EXECUTE: begin
        bus.aluControl = w_funct_alu;
        w_next         = w_funct_ok ? S_ALUWB : S_FETCH;
      end
      S_ALUWB: begin
        bus.regDst      = 1'b1;
        bus.writeEnable = 1'b1;
        bus.aluControl  = r_alu_hold;
        w_next          = S_FETCH;
      end
      S_BRANCH: begin
        bus.aluControl = ALU_SUB;
        bus.pcSrc      = bus.zero;
        bus.pcWrite    = bus.zero;
        w_next         = S_FETCH;
      end
      S_ADDIEX: begin
        bus.aluSrc     = 1'b1;
        bus.aluControl = ALU_ADD;
        w_next         = S_ADDIWB;
      end
      S_ADDIWB: begin
        bus.aluSrc      = 1'b1;
        bus.aluControl  = ALU_ADD;
        bus.writeEnable = 1'b1;
        w_next          = S_FETCH;
      end
      S_JUMP: begin
        bus.jump    = 1'b1;
        bus.pcWrite = 1'b1;
        w_next      = S_FETCH;
      end
      S_HALT: begin
        bus.halted = 1'b1;
        w_next     = S_HALT;
      end
      default: w_next = S_FETCH;
    endcase

    bus.busError = r_bus_err;
    bus.state    = r_state;

    if (reset) begin
      bus.memToReg    = 1'b0;
      bus.pcSrc       = 1'b0;
      bus.aluSrc      = 1'b0;
      bus.regDst      = 1'b0;
      bus.writeEnable = 1'b0;
      bus.jump        = 1'b0;
      bus.aluControl  = 4'b0000;
      bus.pcWrite     = 1'b0;
      bus.irWrite     = 1'b0;
      bus.memRead     = 1'b0;
      bus.memWrite    = 1'b0;
      bus.illegal     = 1'b0;
      bus.busError    = 1'b0;
      bus.halted      = 1'b0;
      bus.state       = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_FETCH;
      r_wait     <= '0;
      r_bus_err  <= 1'b0;
      r_is_sw    <= 1'b0;
      r_alu_hold <= ALU_ADD;
    end else begin
      r_state <= w_next;
      if (w_timeout) r_bus_err <= 1'b1;
      if (w_in_mem && !bus.memReady && !w_timeout) r_wait <= r_wait + 1'b1;
      else                                         r_wait <= '0;
      if (r_state == S_DECODE)  r_is_sw    <= (bus.opcode == OP_SW);
      if (r_state == S_EXECUTE) r_alu_hold <= w_funct_alu;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// =============================================================================
// tb_multicycle_control : table-driven check of the multi-cycle control FSM (rev 1.0)
// =============================================================================
module tb_multicycle_control;

  localparam logic [5:0] RT  = 6'b000000;
  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] ADI = 6'b001000;
  localparam logic [5:0] JMP = 6'b000010;
  localparam logic [5:0] HLT = 6'b111111;
  localparam logic [5:0] BAD = 6'b010101;

  localparam logic [5:0] FADD = 6'b100000;
  localparam logic [5:0] FSUB = 6'b100010;
  localparam logic [5:0] FAND = 6'b100100;
  localparam logic [5:0] FOR  = 6'b100101;
  localparam logic [5:0] FSLT = 6'b101010;

  // Packed view: {memToReg,pcSrc,aluSrc,regDst,writeEnable,jump,aluControl,
  //               pcWrite,irWrite,memRead,memWrite,illegal,busError,halted,state}
  localparam logic [20:0] MTR = 21'd1 << 20;
  localparam logic [20:0] PS  = 21'd1 << 19;
  localparam logic [20:0] AS  = 21'd1 << 18;
  localparam logic [20:0] RD  = 21'd1 << 17;
  localparam logic [20:0] WE  = 21'd1 << 16;
  localparam logic [20:0] JU  = 21'd1 << 15;
  localparam logic [20:0] PCW = 21'd1 << 10;
  localparam logic [20:0] IRW = 21'd1 << 9;
  localparam logic [20:0] MR  = 21'd1 << 8;
  localparam logic [20:0] MW  = 21'd1 << 7;
  localparam logic [20:0] ILL = 21'd1 << 6;
  localparam logic [20:0] BE  = 21'd1 << 5;
  localparam logic [20:0] HT  = 21'd1 << 4;
  localparam logic [20:0] AL_ADD = 21'b0010 << 11;
  localparam logic [20:0] AL_SUB = 21'b0110 << 11;
  localparam logic [20:0] AL_AND = 21'b0000 << 11;
  localparam logic [20:0] AL_OR  = 21'b0001 << 11;
  localparam logic [20:0] AL_SLT = 21'b0111 << 11;
  localparam logic [20:0] F_DONE = MR | IRW | PCW;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        rdy;
    logic [20:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;
  vec_t vecs[$];

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [20:0] w_got;
  assign w_got = {bus.memToReg, bus.pcSrc, bus.aluSrc, bus.regDst, bus.writeEnable,
                  bus.jump, bus.aluControl, bus.pcWrite, bus.irWrite, bus.memRead,
                  bus.memWrite, bus.illegal, bus.busError, bus.halted, bus.state};

  function automatic logic [20:0] S(input int s);
    return 21'(s);
  endfunction

  function automatic void add(input logic r, input logic [5:0] op, input logic [5:0] fn,
                              input logic z, input logic rdy, input logic [20:0] exp);
    vec_t v;
    v.rst = r; v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.exp = exp;
    vecs.push_back(v);
  endfunction

  // One clock: drive inputs, compare on the falling edge, then cross the rising edge.
  task automatic cyc(input logic r, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic rdy, input logic [20:0] exp, input string name);
    reset        = r;
    bus.opcode   = op;
    bus.funct    = fn;
    bus.zero     = z;
    bus.memReady = rdy;
    @(negedge clk);
    n_cmp++;
    if (w_got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %06h want %06h (state got %0d want %0d)",
               name, w_got, exp, w_got[3:0], exp[3:0]);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; bus.opcode = RT; bus.funct = FADD; bus.zero = 1'b0; bus.memReady = 1'b0;

    add(1, RT, FADD, 0, 0, 21'd0);
    add(1, RT, FADD, 1, 1, 21'd0);
    // R-type ADD, then funct changed during ALUWB must not matter
    add(0, RT, FADD, 0, 0, MR | S(0));
    add(0, RT, FADD, 0, 1, F_DONE | S(0));
    add(0, RT, FADD, 0, 1, S(1));
    add(0, RT, FADD, 0, 1, AL_ADD | S(6));
    add(0, RT, FSUB, 0, 1, RD | WE | AL_ADD | S(7));
    // LW with three wait cycles in MEMRD; opcode swapped after DECODE
    add(0, LW, 0, 0, 1, F_DONE | S(0));
    add(0, LW, 0, 0, 1, S(1));
    add(0, SW, 0, 0, 1, AS | AL_ADD | S(2));
    add(0, SW, 0, 0, 0, MR | AS | AL_ADD | S(3));
    add(0, SW, 0, 0, 0, MR | AS | AL_ADD | S(3));
    add(0, SW, 0, 0, 0, MR | AS | AL_ADD | S(3));
    add(0, SW, 0, 0, 1, MR | AS | AL_ADD | S(3));
    add(0, SW, 0, 0, 0, MTR | WE | S(4));
    // SW zero-wait
    add(0, SW, 0, 0, 1, F_DONE | S(0));
    add(0, SW, 0, 0, 1, S(1));
    add(0, SW, 0, 0, 1, AS | AL_ADD | S(2));
    add(0, SW, 0, 0, 1, MW | AS | AL_ADD | S(5));
    // BEQ taken then not taken
    add(0, BEQ, 0, 0, 1, F_DONE | S(0));
    add(0, BEQ, 0, 0, 1, S(1));
    add(0, BEQ, 0, 1, 1, PS | PCW | AL_SUB | S(8));
    add(0, BEQ, 0, 1, 1, F_DONE | S(0));
    add(0, BEQ, 0, 1, 1, S(1));
    add(0, BEQ, 0, 0, 1, AL_SUB | S(8));
    // ADDI and J
    add(0, ADI, 0, 0, 1, F_DONE | S(0));
    add(0, ADI, 0, 0, 1, S(1));
    add(0, ADI, 0, 0, 1, AS | AL_ADD | S(9));
    add(0, ADI, 0, 0, 1, AS | AL_ADD | WE | S(10));
    add(0, JMP, 0, 0, 1, F_DONE | S(0));
    add(0, JMP, 0, 0, 1, S(1));
    add(0, JMP, 0, 0, 1, JU | PCW | S(11));
    // Remaining funct codes
    add(0, RT, FSUB, 0, 1, F_DONE | S(0));
    add(0, RT, FSUB, 0, 1, S(1));
    add(0, RT, FSUB, 0, 1, AL_SUB | S(6));
    add(0, RT, FSUB, 0, 1, RD | WE | AL_SUB | S(7));
    add(0, RT, FAND, 0, 1, F_DONE | S(0));
    add(0, RT, FAND, 0, 1, S(1));
    add(0, RT, FAND, 0, 1, AL_AND | S(6));
    add(0, RT, FAND, 0, 1, RD | WE | AL_AND | S(7));
    add(0, RT, FOR,  0, 1, F_DONE | S(0));
    add(0, RT, FOR,  0, 1, S(1));
    add(0, RT, FOR,  0, 1, AL_OR | S(6));
    add(0, RT, FOR,  0, 1, RD | WE | AL_OR | S(7));
    add(0, RT, FSLT, 0, 1, F_DONE | S(0));
    add(0, RT, FSLT, 0, 1, S(1));
    add(0, RT, FSLT, 0, 1, AL_SLT | S(6));
    add(0, RT, FSLT, 0, 1, RD | WE | AL_SLT | S(7));
    // Unknown funct: ADD, skip write-back
    add(0, RT, 6'b000000, 0, 1, F_DONE | S(0));
    add(0, RT, 6'b000000, 0, 1, S(1));
    add(0, RT, 6'b000000, 0, 1, AL_ADD | S(6));
    add(0, RT, 6'b000000, 0, 0, MR | S(0));
    // Illegal opcode
    add(0, BAD, 0, 0, 1, F_DONE | S(0));
    add(0, BAD, 0, 0, 1, ILL | S(1));
    add(0, BAD, 0, 0, 0, MR | S(0));
    // Reset during MEMWR aborts without strobes
    add(0, SW, 0, 0, 1, F_DONE | S(0));
    add(0, SW, 0, 0, 1, S(1));
    add(0, SW, 0, 0, 1, AS | AL_ADD | S(2));
    add(0, SW, 0, 0, 0, MW | AS | AL_ADD | S(5));
    add(1, SW, 0, 0, 1, 21'd0);
    add(0, SW, 0, 0, 0, MR | S(0));
    // HALT opcode
    add(0, HLT, 0, 0, 1, F_DONE | S(0));
    add(0, HLT, 0, 0, 1, S(1));
    add(0, HLT, 0, 0, 1, HT | S(15));

    foreach (vecs[i])
      cyc(vecs[i].rst, vecs[i].op, vecs[i].fn, vecs[i].z, vecs[i].rdy, vecs[i].exp,
          $sformatf("vec%0d", i));

    for (int k = 0; k < 20; k++)
      cyc(0, 6'($urandom), 6'($urandom), 1'($urandom), 1'($urandom), HT | S(15),
          $sformatf("halt_hold%0d", k));

    // FETCH timeout: 15 cycles without memReady
    cyc(1, JMP, 0, 0, 0, 21'd0, "to_reset");
    for (int k = 1; k <= 15; k++)
      cyc(0, JMP, 0, 0, 0, MR | S(0), $sformatf("to_wait%0d", k));
    for (int k = 0; k < 3; k++)
      cyc(0, JMP, 0, 0, 1'($urandom), HT | BE | S(15), $sformatf("to_halt%0d", k));

    // memReady arriving on the 15th cycle completes without error
    cyc(1, JMP, 0, 0, 0, 21'd0, "edge_reset");
    for (int k = 1; k <= 14; k++)
      cyc(0, JMP, 0, 0, 0, MR | S(0), $sformatf("edge_wait%0d", k));
    cyc(0, JMP, 0, 0, 1, F_DONE | S(0), "edge_ready15");
    cyc(0, JMP, 0, 0, 0, S(1), "edge_decode");
    cyc(0, JMP, 0, 0, 0, JU | PCW | S(11), "edge_jump");

    // MEMRD timeout after a completed fetch
    cyc(0, LW, 0, 0, 1, F_DONE | S(0), "rdto_fetch");
    cyc(0, LW, 0, 0, 0, S(1), "rdto_decode");
    cyc(0, LW, 0, 0, 0, AS | AL_ADD | S(2), "rdto_memadr");
    for (int k = 1; k <= 15; k++)
      cyc(0, LW, 0, 0, 0, MR | AS | AL_ADD | S(3), $sformatf("rdto_wait%0d", k));
    cyc(0, LW, 0, 0, 0, HT | BE | S(15), "rdto_halt");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
